// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, fetch handshake, instruction register and microcode step counter.
// Define IFETCH_PREFETCH_EN to add a one-entry prefetch buffer for zero-bubble back-to-back issue.
module instr_fetch_stage #(
    parameter int WORD_SIZE = 16,
    parameter int STEP_W = 3,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_valid,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 exec_done,
    input  logic                 branch_en,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 ir_valid,
    output logic [STEP_W-1:0]    ustep
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t state;
    logic [WORD_SIZE-1:0] pc;
`ifdef IFETCH_PREFETCH_EN
    logic [WORD_SIZE-1:0] pbuf;
    logic pbuf_full;
    assign mem_req = (state == FETCH) || !pbuf_full;
`else
    assign mem_req = (state == FETCH);
`endif
    assign mem_addr = pc;
    assign ir_valid = (state == EXEC);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            instruction <= '0;
            ustep <= '0;
`ifdef IFETCH_PREFETCH_EN
            pbuf <= '0;
            pbuf_full <= 1'b0;
`endif
        end else if (state == FETCH) begin
            if (mem_valid) begin
                instruction <= mem_rdata;
                pc <= pc + 1'b1;
                ustep <= '0;
                state <= EXEC;
            end
        end else if (exec_done) begin
            ustep <= '0;
            state <= FETCH;
            if (branch_en) pc <= branch_target;
`ifdef IFETCH_PREFETCH_EN
            pbuf_full <= 1'b0;
            if (!branch_en && pbuf_full) begin
                instruction <= pbuf;
                state <= EXEC;
            end else if (!branch_en && mem_valid) begin
                instruction <= mem_rdata;
                pc <= pc + 1'b1;
                state <= EXEC;
            end
`endif
        end else begin
            ustep <= (ustep == '1) ? ustep : ustep + 1'b1;
`ifdef IFETCH_PREFETCH_EN
            if (!pbuf_full && mem_valid) begin
                pbuf <= mem_rdata;
                pbuf_full <= 1'b1;
                pc <= pc + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed scenarios plus a randomized run against an instruction-level model.
module tb_instr_fetch_stage;
    logic clk = 0, rst_n = 0;
    logic mem_req, ir_valid;
    logic mem_valid = 0, exec_done = 0, branch_en = 0;
    logic [15:0] mem_addr, instruction;
    logic [15:0] mem_rdata = 0, branch_target = 0;
    logic [2:0] ustep;
    int checks = 0, errors = 0;

    instr_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .exec_done(exec_done),
        .branch_en(branch_en), .branch_target(branch_target),
        .instruction(instruction), .ir_valid(ir_valid), .ustep(ustep)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a * 16'd40503 + 16'h1357;
    endfunction

    task automatic idle();
        mem_valid = 0; exec_done = 0; branch_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0; idle();
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); #2; rst_n = 0; idle(); #1;
        checks++; if (instruction !== 16'h0) begin errors++; $display("FAIL reset_instr got %h exp 0000", instruction); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
        checks++; if (ustep !== 3'd0) begin errors++; $display("FAIL reset_ustep got %0d exp 0", ustep); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
    endtask

    task automatic test_first_fetch();
        @(negedge clk); rst_n = 1; mem_valid = 1; mem_rdata = 16'h1234; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin errors++; $display("FAIL first_req got %b/%h exp 1/0000", mem_req, mem_addr); end
        @(negedge clk); mem_valid = 0;
        checks++; if (instruction !== 16'h1234 || ir_valid !== 1'b1) begin errors++; $display("FAIL first_ir got %h/%b exp 1234/1", instruction, ir_valid); end
        checks++; if (ustep !== 3'd0) begin errors++; $display("FAIL first_ustep got %0d exp 0", ustep); end
        exec_done = 1;
        @(negedge clk); exec_done = 0;
        checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h1) begin errors++; $display("FAIL first_next got v%b r%b a%h exp v0 r1 a0001", ir_valid, mem_req, mem_addr); end
    endtask

    task automatic test_stall();
        mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h1) begin errors++; $display("FAIL stall_req[%0d] got %b/%h exp 1/0001", i, mem_req, mem_addr); end
            checks++; if (instruction !== 16'h1234 || ir_valid !== 1'b0) begin errors++; $display("FAIL stall_ir[%0d] got %h/%b exp 1234/0", i, instruction, ir_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_ustep();
        mem_valid = 1; mem_rdata = 16'hBEEF;
        @(negedge clk); mem_valid = 0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (ustep !== 3'((i > 7) ? 7 : i)) begin errors++; $display("FAIL ustep[%0d] got %0d exp %0d", i, ustep, (i > 7) ? 7 : i); end
            checks++; if (instruction !== 16'hBEEF || ir_valid !== 1'b1) begin errors++; $display("FAIL ustep_ir[%0d] got %h/%b exp beef/1", i, instruction, ir_valid); end
`ifndef IFETCH_PREFETCH_EN
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL exec_req[%0d] got %b exp 0", i, mem_req); end
`endif
            branch_en = (i == 3); branch_target = 16'h7777;
            exec_done = (i == 9);
            @(negedge clk);
        end
        idle();
        checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h2) begin errors++; $display("FAIL ustep_done got v%b r%b a%h exp v0 r1 a0002", ir_valid, mem_req, mem_addr); end
    endtask

    task automatic test_branch();
        mem_valid = 1; mem_rdata = 16'h1111;
        @(negedge clk); mem_valid = 0; exec_done = 1; branch_en = 1; branch_target = 16'h0040;
        @(negedge clk); idle();
        checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin errors++; $display("FAIL branch_target got v%b r%b a%h exp v0 r1 a0040", ir_valid, mem_req, mem_addr); end
        mem_valid = 1; mem_rdata = 16'h2222;
        @(negedge clk); mem_valid = 0;
        checks++; if (instruction !== 16'h2222) begin errors++; $display("FAIL branch_ir got %h exp 2222", instruction); end
        exec_done = 1; branch_en = 1; branch_target = 16'hFFFF;
        @(negedge clk); idle();
        checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL branch_ffff got %h exp ffff", mem_addr); end
        mem_valid = 1; mem_rdata = 16'h3333;
        @(negedge clk); mem_valid = 0; exec_done = 1;
        checks++; if (instruction !== 16'h3333) begin errors++; $display("FAIL wrap_ir got %h exp 3333", instruction); end
        @(negedge clk); idle();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %b/%h exp 1/0000", mem_req, mem_addr); end
    endtask

    task automatic test_async_reset();
        mem_valid = 1; mem_rdata = 16'h4444;
        @(negedge clk); mem_valid = 0;
        repeat (4) @(negedge clk);
        checks++; if (ustep !== 3'd4) begin errors++; $display("FAIL pre_reset_ustep got %0d exp 4", ustep); end
        #2; rst_n = 0; #1;
        checks++; if (instruction !== 16'h0 || ir_valid !== 1'b0 || ustep !== 3'd0) begin errors++; $display("FAIL async_reset got %h/%b/%0d exp 0000/0/0", instruction, ir_valid, ustep); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL async_reset_pc got %h exp 0000", mem_addr); end
        @(negedge clk); rst_n = 1; mem_valid = 1; mem_rdata = 16'h5555; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin errors++; $display("FAIL refetch got %b/%h exp 1/0000", mem_req, mem_addr); end
        @(negedge clk); mem_valid = 0;
        checks++; if (instruction !== 16'h5555 || ir_valid !== 1'b1) begin errors++; $display("FAIL refetch_ir got %h/%b exp 5555/1", instruction, ir_valid); end
    endtask

`ifndef IFETCH_PREFETCH_EN
    task automatic test_random();
        logic [15:0] m_pc = 16'h0, m_ir = 16'h0;
        bit busy = 0;
        int age = 0;
        do_reset();
        repeat (500) begin
            @(negedge clk);
            checks++; if (ir_valid !== busy || instruction !== m_ir) begin errors++; $display("FAIL rand_ir got %b/%h exp %b/%h", ir_valid, instruction, busy, m_ir); end
            checks++; if (ustep !== 3'((age > 7) ? 7 : age)) begin errors++; $display("FAIL rand_ustep got %0d exp %0d", ustep, (age > 7) ? 7 : age); end
            checks++; if (mem_req !== !busy || (!busy && mem_addr !== m_pc)) begin errors++; $display("FAIL rand_req got %b/%h exp %b/%h", mem_req, mem_addr, !busy, m_pc); end
            mem_valid = 1'($urandom_range(0, 1));
            mem_rdata = mem_valid ? word_at(m_pc) : 16'($urandom);
            exec_done = ($urandom_range(0, 3) == 0);
            branch_en = 1'($urandom_range(0, 1));
            branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            @(posedge clk);
            if (!busy) begin
                if (mem_valid) begin m_ir = word_at(m_pc); m_pc = m_pc + 16'd1; busy = 1; age = 0; end
            end else if (exec_done) begin
                busy = 0; age = 0;
                if (branch_en) m_pc = branch_target;
            end else age++;
        end
        idle();
    endtask
`else
    task automatic test_prefetch();
        do_reset();
        mem_valid = 1; mem_rdata = 16'hA000;
        @(negedge clk); mem_rdata = 16'hB000;
        checks++; if (instruction !== 16'hA000 || ir_valid !== 1'b1) begin errors++; $display("FAIL pf_first got %h/%b exp a000/1", instruction, ir_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h1) begin errors++; $display("FAIL pf_req got %b/%h exp 1/0001", mem_req, mem_addr); end
        @(negedge clk); mem_valid = 0;
        checks++; if (mem_req !== 1'b0 || ustep !== 3'd1) begin errors++; $display("FAIL pf_full got %b/%0d exp 0/1", mem_req, ustep); end
        exec_done = 1;
        @(negedge clk); exec_done = 0;
        checks++; if (instruction !== 16'hB000 || ir_valid !== 1'b1 || ustep !== 3'd0) begin errors++; $display("FAIL pf_b2b got %h/%b/%0d exp b000/1/0", instruction, ir_valid, ustep); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h2) begin errors++; $display("FAIL pf_next got %b/%h exp 1/0002", mem_req, mem_addr); end
        mem_valid = 1; mem_rdata = 16'hC000;
        @(negedge clk); mem_valid = 0; exec_done = 1; branch_en = 1; branch_target = 16'h0100;
        @(negedge clk); idle();
        checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL pf_branch got v%b r%b a%h exp v0 r1 a0100", ir_valid, mem_req, mem_addr); end
        mem_valid = 1; mem_rdata = 16'hD000;
        @(negedge clk); mem_valid = 0;
        checks++; if (instruction !== 16'hD000) begin errors++; $display("FAIL pf_drop got %h exp d000", instruction); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_ustep();
        test_branch();
        test_async_reset();
`ifndef IFETCH_PREFETCH_EN
        test_random();
`else
        test_prefetch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
